// File: rtl/mult_div_ctrl.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO, runs a fixed-latency busy
// sequence per mult/div and raises the D-stage stall while a result is pending.
module mult_div_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_D,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;

  // mult/multu/div/divu all have op[2] clear
  function automatic logic is_md(input logic [2:0] o);
    return (o[2] == 1'b0);
  endfunction

  function automatic logic [63:0] mul_s(input logic signed [31:0] x, input logic signed [31:0] y);
    logic signed [63:0] xs, ys, p;
    xs = x;
    ys = y;
    p  = xs * ys;
    return p;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] x, input logic [31:0] y);
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Magnitude divide then fix signs; avoids the INT_MIN / -1 overflow case.
  function automatic logic [63:0] div_s(input logic signed [31:0] x, input logic signed [31:0] y);
    logic [31:0] mx, my, q, r;
    mx = x[31] ? (~x + 32'd1) : x;
    my = y[31] ? (~y + 32'd1) : y;
    q  = mx / my;
    r  = mx % my;
    if (x[31] ^ y[31]) q = ~q + 32'd1;
    if (x[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] x, input logic [31:0] y);
    return {x % y, x / y};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_md(op)) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = op[1] ? DIV_LD : MULT_LD;
            state_d = BUSY;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          case (op_q[1:0])
            2'b00: {hi_d, lo_d} = mul_s(a_q, b_q);
            2'b01: {hi_d, lo_d} = mul_u(a_q, b_q);
            2'b10: if (b_q != 32'd0) {hi_d, lo_d} = div_s(a_q, b_q);
            default: if (b_q != 32'd0) {hi_d, lo_d} = div_u(a_q, b_q);
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Covers the start cycle itself, before busy has risen
  assign stall_D = md_use_D & (busy_q | (start & is_md(op)));
  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
